// File: rtl/mips_sim_pkg.sv
// Shared types and default constants for the MIPS run monitor.
package mips_sim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_HALTED  = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_state_e;

  localparam int unsigned DEF_XLEN         = 32;
  localparam int unsigned DEF_RESET_CYCLES = 1;
  localparam int unsigned DEF_MAX_CYCLES   = 20;
  localparam int unsigned DEF_STALL_LIMIT  = 4;
  localparam int unsigned DEF_TRACE_DEPTH  = 8;
  localparam int unsigned CYCLE_W          = 32;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int unsigned trace_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mips_run_monitor_if.sv
// Control/status and trace-readout bundle between a run controller and the monitor.
interface mips_run_monitor_if
  import mips_sim_pkg::*;
#(
  parameter int unsigned XLEN        = DEF_XLEN,
  parameter int unsigned TRACE_DEPTH = DEF_TRACE_DEPTH
);
  localparam int unsigned CNT_W = trace_cnt_w(TRACE_DEPTH);

  logic               start;
  logic               cpu_reset;
  logic [XLEN-1:0]    pc;
  logic               halted;
  logic               timed_out;
  logic [CYCLE_W-1:0] cycle_count;
  logic               trace_rd_en;
  logic [XLEN-1:0]    trace_rd_data;
  logic [CNT_W-1:0]   trace_count;
  logic               trace_empty;

  modport master (
    output start, pc, trace_rd_en,
    input  cpu_reset, halted, timed_out, cycle_count,
    input  trace_rd_data, trace_count, trace_empty
  );

  modport slave (
    input  start, pc, trace_rd_en,
    output cpu_reset, halted, timed_out, cycle_count,
    output trace_rd_data, trace_count, trace_empty
  );

endinterface

// File: rtl/pc_trace_buf.sv
// Circular PC trace: writes overwrite the oldest entry when full; oldest entry is fall-through.
module pc_trace_buf
  import mips_sim_pkg::*;
#(
  parameter int unsigned W     = DEF_XLEN,
  parameter int unsigned DEPTH = DEF_TRACE_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_clear,
  input  logic                          i_wr_en,
  input  logic [W-1:0]                  i_wr_data,
  input  logic                          i_rd_en,
  output logic [W-1:0]                  o_rd_data,
  output logic [trace_cnt_w(DEPTH)-1:0] o_count,
  output logic                          o_empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = trace_cnt_w(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  // A write in the same cycle wins over a pop.
  assign w_pop   = i_rd_en && !w_empty && !i_wr_en;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_wr_en) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_full) r_rd_ptr <= r_rd_ptr + 1'b1;
      else        r_count  <= r_count + 1'b1;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_empty   = w_empty;

endmodule

// File: rtl/mips_run_monitor.sv
// Runs a MIPS core under reset/run control, detects halt (stuck PC) or cycle timeout.
// Optional PC trace buffer built when PC_TRACE_EN is defined.
module mips_run_monitor
  import mips_sim_pkg::*;
#(
  parameter int unsigned XLEN         = DEF_XLEN,
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int unsigned STALL_LIMIT  = DEF_STALL_LIMIT,
  parameter int unsigned TRACE_DEPTH  = DEF_TRACE_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  mips_run_monitor_if.slave  bus
);
  localparam int unsigned HOLD_W  = $clog2(RESET_CYCLES + 1);
  localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

  run_state_e         r_state;
  run_state_e         w_state_nxt;
  logic [HOLD_W-1:0]  r_hold;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [STALL_W-1:0] r_stall;
  logic [STALL_W-1:0] w_stall_nxt;
  logic [CYCLE_W-1:0] r_cycle;
  logic [CYCLE_W-1:0] w_cycle_nxt;
  logic [XLEN-1:0]    r_prev_pc;
  logic [XLEN-1:0]    w_prev_pc_nxt;
  logic               r_cpu_reset;
  logic               r_halted;
  logic               r_timed_out;
  logic               w_restart;
  logic               w_trace_wr;
  logic               w_trace_rd;
  logic               w_match;
  logic               w_halt_hit;
  logic               w_timeout_hit;

  // Next-state and datapath updates; halt takes priority over timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold;
    w_stall_nxt   = r_stall;
    w_cycle_nxt   = r_cycle;
    w_prev_pc_nxt = r_prev_pc;
    w_restart     = 1'b0;
    w_trace_wr    = 1'b0;
    w_trace_rd    = 1'b0;
    w_halt_hit    = 1'b0;
    w_timeout_hit = 1'b0;
    // cycle_count is zero only on the first RUN cycle, which has no previous pc.
    w_match       = (r_cycle != '0) && (bus.pc == r_prev_pc);

    case (r_state)
      ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
        w_trace_rd = bus.trace_rd_en && (r_state != ST_IDLE);
        if (bus.start) begin
          w_state_nxt = ST_HOLD;
          w_restart   = 1'b1;
          w_trace_rd  = 1'b0;
          w_hold_nxt  = '0;
          w_stall_nxt = '0;
          w_cycle_nxt = '0;
        end
      end
      ST_HOLD: begin
        if (r_hold == HOLD_W'(RESET_CYCLES - 1)) w_state_nxt = ST_RUN;
        else                                     w_hold_nxt  = r_hold + 1'b1;
      end
      ST_RUN: begin
        w_trace_wr    = 1'b1;
        w_cycle_nxt   = r_cycle + 1'b1;
        w_prev_pc_nxt = bus.pc;
        w_stall_nxt   = w_match ? r_stall + 1'b1 : '0;
        w_halt_hit    = w_match && (w_stall_nxt == STALL_W'(STALL_LIMIT - 1));
        w_timeout_hit = (w_cycle_nxt == CYCLE_W'(MAX_CYCLES));
        if (w_halt_hit)         w_state_nxt = ST_HALTED;
        else if (w_timeout_hit) w_state_nxt = ST_TIMEOUT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and status registers; flags are decoded from the next state so they are flop outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_stall     <= '0;
      r_cycle     <= '0;
      r_prev_pc   <= '0;
      r_cpu_reset <= 1'b1;
      r_halted    <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold      <= w_hold_nxt;
      r_stall     <= w_stall_nxt;
      r_cycle     <= w_cycle_nxt;
      r_prev_pc   <= w_prev_pc_nxt;
      r_cpu_reset <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_HOLD);
      r_halted    <= (w_state_nxt == ST_HALTED);
      r_timed_out <= (w_state_nxt == ST_TIMEOUT);
    end
  end

  assign bus.cpu_reset   = r_cpu_reset;
  assign bus.halted      = r_halted;
  assign bus.timed_out   = r_timed_out;
  assign bus.cycle_count = r_cycle;

`ifdef PC_TRACE_EN
  pc_trace_buf #(
    .W     (XLEN),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_restart),
    .i_wr_en   (w_trace_wr),
    .i_wr_data (bus.pc),
    .i_rd_en   (w_trace_rd),
    .o_rd_data (bus.trace_rd_data),
    .o_count   (bus.trace_count),
    .o_empty   (bus.trace_empty)
  );
`else
  logic w_unused_trace;

  assign bus.trace_rd_data = '0;
  assign bus.trace_count   = '0;
  assign bus.trace_empty   = 1'b1;
  assign w_unused_trace    = ^{bus.trace_rd_en, w_trace_wr, w_trace_rd, w_restart};
`endif

endmodule
